hist_issue_sched: RTL
=====================

HIST_ISSUE_SCHED -- requirements
Module: hist_issue_sched

Interface
REQ-001 SHALL have parameter DUMP_ADDR, default 8'hFF, meaning the idle-lane address driven to memory (outside the 0..254 counter range; a write there updates no counter).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request packet present.
REQ-005 SHALL have port in_addr  input  128  eight 16-bit lanes, lane i = bits [16i+15:16i]; only bits [16i+7:16i] are used.
REQ-006 SHALL have port in_ready  output  1  block can accept a packet.
REQ-007 SHALL have port mem_a  output  128  eight 16-bit lane addresses to the counter memory.
REQ-008 SHALL have port mem_we  output  1  increment strobe to the counter memory.
REQ-009 SHALL have port busy  output  1  a packet is being issued.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a packet's last increment has been issued.
REQ-011 SHALL have port pkt_count  output  16  packets completed since reset, wraps 16'hFFFF -> 0.

Function
REQ-012 SHALL implement states IDLE and ISSUE; reset state IDLE.
REQ-013 In IDLE: in_ready=1, busy=0, mem_we=0, mem_a = DUMP_ADDR zero-extended in all eight lanes.
REQ-014 IDLE, in_valid=1: SHALL latch in_addr[7:0] of each lane; pending[i]=1 unless lane address == DUMP_ADDR; go to ISSUE if any pending bit is set, else stay IDLE and pulse done (and increment pkt_count) next cycle.
REQ-015 In ISSUE: in_ready=0, busy=1, mem_we=1; in_valid is ignored.
REQ-016 Per ISSUE cycle, lane i SHALL be selected iff pending[i]=1 and no pending lane j<i has the same latched address.
REQ-017 mem_a lane i SHALL be {8'h00, addr[i]} if selected, else {8'h00, DUMP_ADDR}; no two selected lanes carry the same address in one cycle.
REQ-018 At the rising edge closing an ISSUE cycle, selected lanes' pending bits SHALL clear.
REQ-019 When pending becomes all-zero: go to IDLE; done=1 for exactly the first IDLE cycle; pkt_count increments by 1 at that edge.
REQ-020 Issue length SHALL equal the largest multiplicity of any non-dump address in the packet (1..8 cycles); total lane increments issued equal the count of non-dump lanes.
REQ-021 Upper byte of each input lane SHALL be ignored (address 16'h0105 behaves as 8'h05).
REQ-022 mem_a, mem_we, busy, in_ready, done SHALL depend only on registered state (no combinational path from in_valid or in_addr).
REQ-023 Back-to-back: a packet SHALL be acceptable in the same cycle done is high (IDLE).

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, pending=0, latched addresses=DUMP_ADDR, done=0, pkt_count=0, overriding all other inputs.
REQ-025 Reset during ISSUE SHALL abandon the packet: increments already strobed remain, no further mem_we, no done pulse, in_ready=1 the cycle after reset deasserts.

Verification
REQ-026 All-distinct: lanes 0..7 = 0..7 -> one ISSUE cycle, mem_a lanes = 0..7, mem_we=1 one cycle, then done pulse, pkt_count=1.
REQ-027 All-same: eight lanes = 8'h2A -> eight ISSUE cycles, each with only one lane at 8'h2A (lane 0, then 1, ... 7), others 8'hFF; memory word 42 ends at 8.
REQ-028 Mixed: lanes {3,3,5,3,5,7,FF,FF} -> cycle1 lanes0,2,5={3,5,7}; cycle2 lanes1,4={3,5}; cycle3 lane3={3}; counters 3/5/7 = 3/2/1.
REQ-029 All lanes DUMP_ADDR -> no ISSUE cycle, mem_we stays 0, done pulses once, pkt_count +1.
REQ-030 Reset asserted in second ISSUE cycle of the all-same packet -> mem_we 0 after that edge, no done, pkt_count=0, word 42 = 1 or 2 per strobes issued.
REQ-031 pkt_count preset path: 65536 all-dump packets -> pkt_count wraps to 0; in_valid held high throughout -> one packet accepted per IDLE cycle, none in ISSUE.

Source files
------------

// File: rtl/hist_issue_sched.sv
// ---------------------------------------------------------------------------
// hist_issue_sched
//
// Purpose:
//   Takes a packet of eight 8-bit histogram bin addresses and issues
//   increments for them to a counter memory. The memory accepts up to eight
//   lane increments per cycle but cannot take two increments to the same bin
//   in one cycle. Repeated addresses are therefore spread over several
//   cycles. Each cycle, only the lowest-numbered pending lane carrying a
//   given address is issued.
//   Idle lanes carry DUMP_ADDR, which lies outside the counter range, so a
//   write to it updates no counter.
//
// Ports:
//   clk        in   1    single clock, all state changes on the rising edge
//   reset      in   1    synchronous, active-high
//   in_valid   in   1    request packet present (sampled only in IDLE)
//   in_addr    in   128  eight 16-bit lanes; only the low byte of each is used
//   in_ready   out  1    block can accept a packet (IDLE)
//   mem_a      out  128  eight 16-bit lane addresses to the counter memory
//   mem_we     out  1    increment strobe to the counter memory
//   busy       out  1    a packet is being issued
//   done       out  1    one-cycle pulse after a packet's last increment
//   pkt_count  out  16   packets completed since reset, wraps at 16'hFFFF
//
// All outputs decode registered state only. There is no combinational path
// from in_valid or in_addr to any output.
// ---------------------------------------------------------------------------
module hist_issue_sched #(
    parameter logic [7:0] DUMP_ADDR = 8'hFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [127:0] in_addr,
    output logic         in_ready,
    output logic [127:0] mem_a,
    output logic         mem_we,
    output logic         busy,
    output logic         done,
    output logic [15:0]  pkt_count
);

    localparam int LANES = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Registered state
    state_t            r_state;
    logic [7:0]        r_addr [LANES];   // latched lane addresses
    logic [LANES-1:0]  r_pending;        // lanes still owed an increment
    logic              r_done;
    logic [15:0]       r_pkt_count;

    // Combinational helpers
    logic [7:0]        w_in_addr [LANES];
    logic [LANES-1:0]  w_in_pending;
    logic [LANES-1:0]  w_sel;            // lanes issued this cycle
    logic [LANES-1:0]  w_pending_left;   // lanes still pending after this cycle
    logic              w_unused_upper;

    // -----------------------------------------------------------------------
    // Input lane decode. The upper byte of each 16-bit lane is ignored. It is
    // folded into a sink signal so that it is visibly consumed.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
        w_unused_upper = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_in_addr[i]    = in_addr[16*i +: 8];
            w_in_pending[i] = (in_addr[16*i +: 8] != DUMP_ADDR);
            w_unused_upper  = w_unused_upper ^ (^in_addr[16*i+8 +: 8]);
        end
    end

    // -----------------------------------------------------------------------
    // Lane selection. A pending lane is issued unless a lower pending lane
    // holds the same address. Within one cycle this guarantees:
    //   - the selected addresses are all distinct, and
    //   - the lowest pending lane is always selected, so a packet finishes
    //     in exactly max-multiplicity cycles.
    // -----------------------------------------------------------------------
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sel[i] = r_pending[i];
            for (int j = 0; j < i; j++) begin
                if (r_pending[j] && (r_addr[j] == r_addr[i])) begin
                    w_sel[i] = 1'b0;
                end
            end
        end
        w_pending_left = r_pending & ~w_sel;
    end

    // -----------------------------------------------------------------------
    // Memory address lanes. A lane that is not selected, or any lane while
    // the block is IDLE, points at the dump address.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_a = '0;
        for (int i = 0; i < LANES; i++) begin
            if ((r_state == ST_ISSUE) && w_sel[i]) begin
                mem_a[16*i +: 16] = {8'h00, r_addr[i]};
            end else begin
                mem_a[16*i +: 16] = {8'h00, DUMP_ADDR};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM and packet bookkeeping.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so that every register samples pre-edge values and ordering inside the block does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            // NOTE: the latched address array is small and is reset explicitly, so that no stale address can reach mem_a after reset.
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= DUMP_ADDR;
            end
            r_done      <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (in_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            r_addr[i] <= w_in_addr[i];
                        end
                        r_pending <= w_in_pending;
                        if (|w_in_pending) begin
                            r_state <= ST_ISSUE;
                        end else begin
                            // All lanes are dump lanes. The packet completes
                            // without issuing anything.
                            r_done      <= 1'b1;
                            r_pkt_count <= r_pkt_count + 16'd1;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_pending <= w_pending_left;
                    r_done    <= 1'b0;
                    if (w_pending_left == '0) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b1;
                        r_pkt_count <= r_pkt_count + 16'd1;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded directly from registers.
    // -----------------------------------------------------------------------
    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_ISSUE);
    assign mem_we    = (r_state == ST_ISSUE);
    assign done      = r_done;
    assign pkt_count = r_pkt_count;

    // An issue cycle always strobes at least one real lane. ISSUE is only
    // entered with a pending lane, and the lowest pending lane is always
    // selected.
    a_issue_progress : assert property (
        @(posedge clk) disable iff (reset) busy |-> (w_sel != '0)
    );

endmodule
